// File: rtl/crtc_pkg.sv
// crtc_pkg: definitions shared by the CRTC timing generator.
//   - Register index constants for the 6545-style register file (R0..R17).
//   - Vertical FSM state encoding.
//   - Sync-width decode: a 4-bit width field where 0 stands for 16.
package crtc_pkg;

  localparam int R0_H_TOTAL     = 0;
  localparam int R1_H_DISPLAYED = 1;
  localparam int R2_H_SYNC_POS  = 2;
  localparam int R3_SYNC_WIDTH  = 3;
  localparam int R4_V_TOTAL     = 4;
  localparam int R5_V_ADJUST    = 5;
  localparam int R6_V_DISPLAYED = 6;
  localparam int R7_V_SYNC_POS  = 7;
  localparam int R8_MODE        = 8;
  localparam int R9_MAX_SCAN    = 9;
  localparam int R10_CUR_START  = 10;
  localparam int R11_CUR_END    = 11;
  localparam int R12_START_HI   = 12;
  localparam int R13_START_LO   = 13;
  localparam int R14_CUR_HI     = 14;
  localparam int R15_CUR_LO     = 15;
  localparam int R16_LPEN_HI    = 16;
  localparam int R17_LPEN_LO    = 17;

  typedef enum logic {
    V_ACTIVE = 1'b0,
    V_ADJUST = 1'b1
  } v_state_t;

  // A programmed width of 0 means the longest pulse, 16 steps.
  function automatic logic [4:0] sync_width(input logic [3:0] w);
    return (w == 4'd0) ? 5'd16 : {1'b0, w};
  endfunction

endpackage

// File: rtl/crtc_sync_pulse.sv
// crtc_sync_pulse: programmable-width sync pulse generator.
// Ports:
//   clk16  - system clock
//   res_b  - synchronous active-low reset
//   start  - begin (or restart) a pulse; only honoured on a step
//   step   - advance enable (one step = one character or one line)
//   width  - pulse length in steps, 0 encodes 16
//   pulse  - registered pulse output
// A start that lands while a pulse is running reloads the counter, so
// back-to-back pulses merge into one continuous high level.
import crtc_pkg::*;

module crtc_sync_pulse (
  input  logic       clk16,
  input  logic       res_b,
  input  logic       start,
  input  logic       step,
  input  logic [3:0] width,
  output logic       pulse
);

  logic [4:0] count_reg;
  logic [4:0] count_next;

  always_comb begin
    count_next = count_reg;
    if (step) begin
      if (start) begin
        count_next = sync_width(width);
      end else if (count_reg != 5'd0) begin
        count_next = count_reg - 5'd1;
      end
    end
  end

  // The pulse is registered from the next count so it is high during
  // exactly the steps the counter is loaded for, starting with the start step.
  always_ff @(posedge clk16) begin
    if (!res_b) begin
      count_reg <= 5'd0;
      pulse     <= 1'b0;
    end else begin
      count_reg <= count_next;
      pulse     <= (count_next != 5'd0);
    end
  end

endmodule

// File: rtl/crtc_timing.sv
// crtc_timing: programmable 6545-style raster timing generator.
// Ports:
//   clk16, res_b         - clock, synchronous active-low reset
//   cclk_en              - character clock enable; everything advances on it
//   r0..r13 inputs       - live CRTC register values (R0-R7, R9, R12, R13)
//   hsync, vsync         - active-high sync pulses
//   de                   - display enable
//   ma, ra               - character memory address and scan row
//   frame_start          - one-clk16 pulse on the step that loads a new frame
// Outputs are registered from the counter state of the same step, so hsync,
// de and ma line up character for character.
import crtc_pkg::*;

module crtc_timing #(
  parameter int MA_WIDTH = 14,
  parameter int RA_WIDTH = 5
) (
  input  logic                clk16,
  input  logic                res_b,
  input  logic                cclk_en,
  input  logic [7:0]          r0_h_total,
  input  logic [7:0]          r1_h_displayed,
  input  logic [7:0]          r2_h_sync_pos,
  input  logic [7:0]          r3_sync_width,
  input  logic [6:0]          r4_v_total,
  input  logic [4:0]          r5_v_adjust,
  input  logic [6:0]          r6_v_displayed,
  input  logic [6:0]          r7_v_sync_pos,
  input  logic [4:0]          r9_max_scan,
  input  logic [5:0]          r12_start_hi,
  input  logic [7:0]          r13_start_lo,
  output logic                hsync,
  output logic                vsync,
  output logic                de,
  output logic [MA_WIDTH-1:0] ma,
  output logic [RA_WIDTH-1:0] ra,
  output logic                frame_start
);

  v_state_t            state_reg;
  v_state_t            state_next;
  logic [7:0]          h_count_reg;
  logic [RA_WIDTH-1:0] ra_count_reg;
  logic [6:0]          row_reg;
  logic [MA_WIDTH-1:0] row_start_reg;
  // Set by reset: the first character step after reset is a frame load.
  logic                load_pending_reg;

  logic                line_end;
  logic                last_scan;
  logic                last_row;
  logic                to_adjust;
  logic                frame_end;
  logic                frame_load;
  logic                h_de;
  logic                v_de;
  logic                step;
  logic                hsync_start;
  logic                vsync_start;
  logic                vsync_step;
  logic [MA_WIDTH-1:0] start_addr;

  assign start_addr = MA_WIDTH'({r12_start_hi, r13_start_lo});
  assign line_end   = (h_count_reg == r0_h_total);
  assign last_scan  = (ra_count_reg == RA_WIDTH'(r9_max_scan));
  assign last_row   = (row_reg == r4_v_total);
  assign h_de       = (h_count_reg < r1_h_displayed);
  assign frame_load = load_pending_reg | frame_end;

  // ---------------- vertical FSM: state register ----------------
  always_ff @(posedge clk16) begin
    if (!res_b) begin
      state_reg <= V_ACTIVE;
    end else begin
      state_reg <= state_next;
    end
  end

  // ---------------- vertical FSM: next state ----------------
  always_comb begin
    state_next = state_reg;
    to_adjust  = 1'b0;
    frame_end  = 1'b0;
    case (state_reg)
      V_ACTIVE: begin
        if (line_end && last_scan && last_row) begin
          if (r5_v_adjust != 5'd0) begin
            to_adjust = 1'b1;
          end else begin
            frame_end = 1'b1;
          end
        end
      end
      V_ADJUST: begin
        // Adjust lines reuse the scan counter, counting 0..R5-1.
        if (line_end && (ra_count_reg == RA_WIDTH'(r5_v_adjust - 5'd1))) begin
          frame_end = 1'b1;
        end
      end
      default: begin
        state_next = V_ACTIVE;
      end
    endcase
    if (cclk_en) begin
      if (load_pending_reg || frame_end) begin
        state_next = V_ACTIVE;
      end else if (to_adjust) begin
        state_next = V_ADJUST;
      end
    end
  end

  // ---------------- vertical FSM: outputs ----------------
  always_comb begin
    v_de = (state_reg == V_ACTIVE) && (row_reg < r6_v_displayed);
  end

  // ---------------- counters and registered outputs ----------------
  always_ff @(posedge clk16) begin
    if (!res_b) begin
      h_count_reg      <= 8'd0;
      ra_count_reg     <= '0;
      row_reg          <= 7'd0;
      row_start_reg    <= '0;
      load_pending_reg <= 1'b1;
      de               <= 1'b0;
      ma               <= '0;
      ra               <= '0;
      frame_start      <= 1'b0;
    end else begin
      frame_start <= 1'b0;
      if (cclk_en) begin
        ra <= ra_count_reg;
        // The post-reset load step has no real raster position behind it.
        de <= h_de & v_de & ~load_pending_reg;
        if (frame_load) begin
          h_count_reg      <= 8'd0;
          ra_count_reg     <= '0;
          row_reg          <= 7'd0;
          row_start_reg    <= start_addr;
          ma               <= start_addr;
          frame_start      <= 1'b1;
          load_pending_reg <= 1'b0;
        end else begin
          ma <= row_start_reg + MA_WIDTH'(h_count_reg);
          // No clamping: if R0 drops below h_count the counter wraps via 255.
          h_count_reg <= line_end ? 8'd0 : h_count_reg + 8'd1;
          if (line_end) begin
            if (state_reg == V_ACTIVE && last_scan) begin
              ra_count_reg  <= '0;
              row_reg       <= row_reg + 7'd1;
              row_start_reg <= row_start_reg + MA_WIDTH'(r1_h_displayed);
            end else begin
              ra_count_reg <= ra_count_reg + RA_WIDTH'(1);
            end
          end
        end
      end
    end
  end

  // ---------------- sync pulses ----------------
  assign step        = cclk_en & ~load_pending_reg;
  assign hsync_start = (h_count_reg == r2_h_sync_pos);
  // vsync is launched on the first character of line 0 of row R7 and stepped
  // at line starts, so it frames whole lines in step with de and ma.
  assign vsync_start = (h_count_reg == 8'd0) && (state_reg == V_ACTIVE) &&
                       (row_reg == r7_v_sync_pos) && (ra_count_reg == '0);
  assign vsync_step  = step & (h_count_reg == 8'd0);

  crtc_sync_pulse u_hsync (
    .clk16 (clk16),
    .res_b (res_b),
    .start (hsync_start),
    .step  (step),
    .width (r3_sync_width[3:0]),
    .pulse (hsync)
  );

  crtc_sync_pulse u_vsync (
    .clk16 (clk16),
    .res_b (res_b),
    .start (vsync_start),
    .step  (vsync_step),
    .width (r3_sync_width[7:4]),
    .pulse (vsync)
  );

endmodule

// File: doc/crtc_timing.md
# crtc_timing

Video timing generator that consumes the 6545-style CRTC register values the Pi writes into the `crtc` register file. It produces the raster and addressing signals that feed the video shifter: horizontal and vertical sync, display enable, character memory address (MA) and scan-line row address (RA). It replaces the fixed-rate `hvSync` sync source with a programmable one, so software-reprogrammed CRTC values (40/80 column, 50/60 Hz) take effect in hardware.

## Interface
Parameters:
- `MA_WIDTH`, 14, width of the character address counter (R12[5:0]:R13).
- `RA_WIDTH`, 5, width of the row address counter (R9 is 5 bits).

Ports:
- Reset is synchronous, active-low (`res_b`); one clock (`clk16`).
- `clk16`  in  1  16 MHz system clock; all state changes on its rising edge.
- `res_b`  in  1  synchronous active-low reset.
- `cclk_en`  in  1  character-clock enable, one `clk16` cycle wide; all counters advance only when high.
- `r0_h_total`  in  8  total characters per line minus 1.
- `r1_h_displayed`  in  8  displayed characters per line.
- `r2_h_sync_pos`  in  8  character index at which hsync starts.
- `r3_sync_width`  in  8  [3:0] hsync width in chars, [7:4] vsync width in lines; 0 encodes 16.
- `r4_v_total`  in  7  total character rows minus 1.
- `r5_v_adjust`  in  5  extra scan lines after the last row.
- `r6_v_displayed`  in  7  displayed character rows.
- `r7_v_sync_pos`  in  7  row index at which vsync starts.
- `r9_max_scan`  in  5  scan lines per row minus 1.
- `r12_start_hi`  in  6  start address [13:8].
- `r13_start_lo`  in  8  start address [7:0].
- `hsync`  out  1  horizontal sync, active high.
- `vsync`  out  1  vertical sync, active high.
- `de`  out  1  display enable.
- `ma`  out  14  character memory address.
- `ra`  out  5  scan line within the current character row.
- `frame_start`  out  1  one-`clk16` pulse on the `cclk_en` cycle that begins a new frame.

## Operation
- `h_count` (8b): on `cclk_en`, if `h_count == R0` it goes to 0 and `line_end` is asserted for that step; otherwise it increments.
- `h_de = (h_count < R1)`. `de = h_de & v_de`, registered.
- hsync: asserted on the step where `h_count` becomes R2. It is held for `w = R3[3:0]` (0 maps to 16) character steps, then deasserted. If R2 > R0, hsync never fires.
- Line end advances the vertical logic:
  - If `ra == R9`: `ra` goes to 0, `row` increments, and `row_start` gets `row_start + R1`.
  - Otherwise `ra` increments.
- Vertical FSM:
  - `V_ACTIVE`: at the line end of `ra == R9 && row == R4`, go to `V_ADJUST` if R5 != 0, else end the frame.
  - `V_ADJUST`: `ra` counts 0..R5-1. At the line end of `ra == R5-1`, end the frame.
- Frame end: `row` and `ra` go to 0. `row_start` and `ma` load `{R12,R13}` (sampled only here). `frame_start` pulses and the FSM returns to `V_ACTIVE`.
- `v_de = (state == V_ACTIVE) && (row < R6)`.
- vsync: asserted at the line end that enters `row == R7, ra == 0`. It is held for `R3[7:4]` lines (0 maps to 16) and counted on line ends.
- `ma = row_start + h_count` within a line. The addition is modulo 2^14 and wraps silently.
- R0–R9 are used live. A change mid-frame takes effect at the next comparison; counters are never forced. If `h_count > R0` after R0 is lowered, the counter wraps through 255 to 0.

## Timing
- Reset is synchronous on `clk16`. It overrides `cclk_en`.
- Reset values: `hsync=0`, `vsync=0`, `de=0`, `ma=0`, `ra=0`, `frame_start=0`. Internal counters go to 0, `row_start` goes to 0, FSM goes to `V_ACTIVE`.
- After reset release, the first `cclk_en` performs a frame load: `ma={R12,R13}`, `frame_start=1`.
- All outputs are registered and change only on `cclk_en` cycles. Exception: `frame_start` clears on the next `clk16` cycle.
- Output latency is one `cclk_en` step from counter state to outputs. `hsync`, `de` and `ma` are mutually aligned.
- If a new sync start coincides with an active pulse (width ≥ period), the width counter reloads and the pulse stays high.
- If a reset is asserted mid-frame, all state is dropped; no partial pulse completes.

## Structure
- Shared package `crtc_pkg` holds:
  - localparams for register indices R0..R17,
  - the vertical FSM enum (`V_ACTIVE`, `V_ADJUST`),
  - the sync-width decode function (0 maps to 16).
- Sub-module `crtc_sync_pulse` is instantiated twice, once for hsync and once for vsync. Its ports are `start`, `step`, `width[3:0]` and `pulse`; it contains a 5-bit down-counter.
- `crtc` exports its register array as the R-ports above; the top level wires them to this block.

## Test plan
All scenarios use the small config unless stated: R0=9, R1=6, R2=7, R3=0x22, R4=3, R5=1, R6=2, R7=3, R9=1, start=0x100, `cclk_en` every 4 clocks.
- Reset then run → `frame_start` pulses every 90 `cclk_en` steps (9 lines × 10 chars). All outputs read 0 during reset.
- Horizontal → `hsync` is high for h_count 7–8 every line. `de` is high for h_count 0–5 on rows 0–1 only. First-line `ma` reads 0x100..0x105.
- Addressing → row 1, ra=0 starts at `ma=0x106`. `ra` toggles 0,1 per row. Both lines of a row repeat the same `ma` sequence.
- Vertical → `vsync` rises entering row 3 line 0 and lasts 2 lines. One adjust line (FSM in `V_ADJUST`, de=0) precedes the frame restart.
- Width 0 and wrap → R3=0x00 gives a 16-char hsync that spans the line wrap. start=0x3FFE gives `ma` 0x3FFE, 0x3FFF, 0x0000.
- Mid-frame reprogram and reset → lowering R0 to 5 mid-line gives the next line length 6. Asserting `res_b=0` mid-vsync drops `vsync` on the next `clk16`.
